// File: rtl/icb_dma_master.sv
// ICB initiator copying a block of 32-bit words in bursts of up to BURST_LEN words, one transaction outstanding.
// Optional macro ICB_DMA_ERR_ABORT_EN: an errored response ends the transfer immediately.
module icb_dma_master #(
    parameter int BURST_LEN = 8,
    parameter int LEN_W     = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_addr,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CMD = 3'd1,
        ST_RD_RSP = 3'd2,
        ST_WR_CMD = 3'd3,
        ST_WR_RSP = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [31:0]       rd_ptr_r;
    logic [31:0]       wr_ptr_r;
    logic [LEN_W-1:0]  rem_r;
    logic [CNT_W-1:0]  burst_cnt_r;
    logic [CNT_W-1:0]  fill_r;
    logic [CNT_W-1:0]  pop_idx_r;
    logic [31:0]       buf_mem_r [BURST_LEN];
    logic              err_r;
    logic              busy_r;
    logic              done_r;

    logic              cmd_hs_s;
    logic              rsp_hs_s;
    logic              abort_s;
    logic              burst_last_s;
    logic              buf_last_s;
    logic              rem_last_s;
    logic [CNT_W-1:0]  burst_sz_s;

    assign cmd_hs_s     = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs_s     = icb_rsp_valid & icb_rsp_ready;
    assign burst_last_s = (burst_cnt_r + CNT_W'(1)) == burst_sz_s;
    assign buf_last_s   = (pop_idx_r + CNT_W'(1)) == fill_r;
    assign rem_last_s   = (rem_r == LEN_W'(1));

`ifdef ICB_DMA_ERR_ABORT_EN
    assign abort_s = icb_rsp_err;
`else
    assign abort_s = 1'b0;
`endif

    // Size of the current burst: the remaining words, capped at the buffer depth
    always_comb begin
        burst_sz_s = CNT_W'(BURST_LEN);
        if (rem_r >= LEN_W'(BURST_LEN)) begin
            burst_sz_s = CNT_W'(BURST_LEN);
        end else begin
            burst_sz_s = rem_r[CNT_W-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len != LEN_W'(0)) begin
                        state_s = ST_RD_CMD;
                    end else begin
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                if (cmd_hs_s) begin
                    state_s = ST_RD_RSP;
                end else begin
                    state_s = ST_RD_CMD;
                end
            end
            ST_RD_RSP: begin
                if (!rsp_hs_s) begin
                    state_s = ST_RD_RSP;
                end else if (abort_s) begin
                    state_s = ST_FIN;
                end else if (burst_last_s) begin
                    state_s = ST_WR_CMD;
                end else begin
                    state_s = ST_RD_CMD;
                end
            end
            ST_WR_CMD: begin
                if (cmd_hs_s) begin
                    state_s = ST_WR_RSP;
                end else begin
                    state_s = ST_WR_CMD;
                end
            end
            ST_WR_RSP: begin
                if (!rsp_hs_s) begin
                    state_s = ST_WR_RSP;
                end else if (abort_s) begin
                    state_s = ST_FIN;
                end else if (!buf_last_s) begin
                    state_s = ST_WR_CMD;
                end else if (rem_last_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RD_CMD;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // ICB command/response signals decoded from registered state, pointers and buffer
    always_comb begin
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'd0;
        icb_cmd_wdata = 32'd0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b0;
        case (state_r)
            ST_RD_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = 1'b1;
                icb_cmd_addr  = rd_ptr_r;
            end
            ST_WR_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_addr  = wr_ptr_r;
                icb_cmd_wdata = buf_mem_r[pop_idx_r[IDX_W-1:0]];
                icb_cmd_wmask = 4'hF;
            end
            ST_RD_RSP, ST_WR_RSP: begin
                icb_rsp_ready = 1'b1;
            end
            default: begin
                icb_rsp_ready = 1'b0;
            end
        endcase
    end

    // Address pointers, word counters, burst buffer and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r    <= 32'd0;
            wr_ptr_r    <= 32'd0;
            rem_r       <= LEN_W'(0);
            burst_cnt_r <= CNT_W'(0);
            fill_r      <= CNT_W'(0);
            pop_idx_r   <= CNT_W'(0);
            err_r       <= 1'b0;
            for (int i = 0; i < BURST_LEN; i++) begin
                buf_mem_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        err_r <= 1'b0;
                        if (len != LEN_W'(0)) begin
                            rd_ptr_r    <= src_addr;
                            wr_ptr_r    <= dst_addr;
                            rem_r       <= len;
                            burst_cnt_r <= CNT_W'(0);
                        end
                    end
                end
                ST_RD_RSP: begin
                    if (rsp_hs_s) begin
                        buf_mem_r[burst_cnt_r[IDX_W-1:0]] <= icb_rsp_rdata;
                        rd_ptr_r <= rd_ptr_r + 32'd4;
                        if (icb_rsp_err) begin
                            err_r <= 1'b1;
                        end
                        if (burst_last_s) begin
                            fill_r      <= burst_cnt_r + CNT_W'(1);
                            pop_idx_r   <= CNT_W'(0);
                            burst_cnt_r <= CNT_W'(0);
                        end else begin
                            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_WR_RSP: begin
                    if (rsp_hs_s) begin
                        if (icb_rsp_err) begin
                            err_r <= 1'b1;
                        end
                        // On abort the counters freeze so rem shows the words not yet written
                        if (!abort_s) begin
                            wr_ptr_r  <= wr_ptr_r + 32'd4;
                            rem_r     <= rem_r - LEN_W'(1);
                            pop_idx_r <= pop_idx_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

    // Registered status outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RD_CMD) || (state_s == ST_RD_RSP) ||
                      (state_s == ST_WR_CMD) || (state_s == ST_WR_RSP);
            done_r <= (state_s == ST_FIN);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: doc/icb_dma_master.md
Name: icb_dma_master

Overview:
ICB initiator that copies a block of 32-bit words from a source address to a destination address using ICB read and write commands. It is the master-side counterpart to the accelerator's ICB slave port. Its main use is to load input, weight and LUT words into the accelerator SRAM windows, and to drain output words back to system memory, without CPU involvement. Data moves in bursts: up to BURST_LEN words are read into an internal buffer, then written out, with one outstanding ICB transaction at a time.

Parameters:
BURST_LEN, 8, depth of the internal word buffer and the maximum number of words read per burst (power of 2, 2..64)
LEN_W, 13, width of the transfer length in words (covers an 8k-word SRAM)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches src_addr, dst_addr and len when idle
src_addr  in  32  source byte address, word aligned
dst_addr  in  32  destination byte address, word aligned
len  in  LEN_W  number of words to copy
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  sticky; set by any icb_rsp_err, cleared on an accepted start
icb_cmd_valid  out  1  command valid
icb_cmd_ready  in  1  command accepted
icb_cmd_read  out  1  1 = read, 0 = write
icb_cmd_addr  out  32  command byte address
icb_cmd_wdata  out  32  write data
icb_cmd_wmask  out  4  byte mask; always 4'hF on writes, 4'h0 on reads
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  response accept
icb_rsp_rdata  in  32  read response data
icb_rsp_err  in  1  response error

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE; address registers, counters and buffer pointers are 0.
  - Reset during a transfer abandons it: no done pulse, and any in-flight response is never accepted.
- FSM states: IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, FIN.
- IDLE:
  - start with len!=0: latch inputs, set rem=len, clear err, go to RD_CMD.
  - start with len==0: go to FIN with no ICB traffic.
  - start in any other state is ignored.
- RD_CMD: icb_cmd_valid=1, icb_cmd_read=1, icb_cmd_addr=rd_ptr. Go to RD_RSP on the cmd_valid&cmd_ready cycle.
- RD_RSP:
  - icb_rsp_ready=1. On rsp_valid, push rdata into the buffer and advance rd_ptr by 4.
  - burst_cnt+1 == min(rem, BURST_LEN): go to WR_CMD.
  - Otherwise: go back to RD_CMD.
- WR_CMD:
  - icb_cmd_valid=1, icb_cmd_read=0, icb_cmd_addr=wr_ptr, icb_cmd_wdata=buffer head, wmask=4'hF.
  - Go to WR_RSP on acceptance.
- WR_RSP:
  - icb_rsp_ready=1. On rsp_valid, pop the buffer, advance wr_ptr by 4, decrement rem.
  - Buffer empty and rem==0: go to FIN.
  - Buffer empty and rem!=0: go to RD_CMD for the next burst.
  - Buffer not empty: go to WR_CMD.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start pulse in FIN is ignored.
- Handshake rules:
  - icb_cmd_* outputs stay stable while valid is high and ready is low.
  - icb_rsp_ready is low outside RD_RSP and WR_RSP.
  - At most one command is outstanding; no new command issues until its response is consumed.
- Addresses: byte address, +4 per word, 32-bit wrap-around with no special handling.
- Burst size is min(rem, BURST_LEN), so the last burst may be short (len=13, BURST_LEN=8 gives bursts of 8 and 5).
- Timing: minimum 2 cycles per ICB transaction (command accept, then response). With a zero-wait slave, an N-word copy takes 4N cycles plus the FIN cycle.
- Any response with icb_rsp_err=1 sets err; rdata is still stored.

Optional Feature:
- Macro: ICB_DMA_ERR_ABORT_EN.
- Defined:
  - An errored response (read or write) is accepted, then the FSM goes straight to FIN: done pulses, err=1.
  - The remaining buffer contents are discarded and rem is frozen; rem is readable as an internal probe only.
- Undefined: errors are only recorded in sticky err, and the transfer runs to completion.

Test Plan:
- Basic copy: src=0x1000, dst=0x2000, len=4, zero-wait slave -> reads at 0x1000..0x100C, then writes at 0x2000..0x200C with matching data; done pulses once, 17 cycles after start; err=0.
- Short last burst: len=13, BURST_LEN=8 -> 8 reads, 8 writes, 5 reads, 5 writes; final write address dst+0x30.
- Backpressure: icb_cmd_ready low for 3 cycles on each command and icb_rsp_valid delayed 2 cycles -> cmd addr/wdata/read stable throughout the stall; data copied correctly; never two commands outstanding.
- len=0 start -> no icb_cmd_valid; done pulses 1 cycle later; busy never rises.
- Error on 3rd read of len=6:
  - Macro off: err=1, all 6 words written.
  - Macro on: exactly 3 reads, 0 writes, done pulses, err=1.
- Reset mid-transfer: assert rst_n low in WR_CMD -> all outputs 0 immediately; a following start with len=2 completes normally.
